// File: rtl/vga_draw_pkg.sv
// Shared types and screen constants for the VGA draw scheduler.
package vga_draw_pkg;

  localparam int X_MAX = 160;
  localparam int Y_MAX = 120;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_DRAW,
    S_DONE,
    S_FAULT
  } state_e;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
  } pixel_t;

  function automatic logic px_visible(input pixel_t p, input int x_lim, input int y_lim);
    return p.plot && (int'(p.x) < x_lim) && (int'(p.y) < y_lim);
  endfunction

endpackage

// File: rtl/vga_draw_scheduler_pixel_clip_reg.sv
// Registered mux + screen clip for the shared VGA pixel port.
module pixel_clip_reg #(
  parameter int X_LIM = 160,
  parameter int Y_LIM = 120
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  vga_draw_pkg::pixel_t pix_a_i,
  input  vga_draw_pkg::pixel_t pix_b_i,
  input  logic                 en_i,
  input  logic                 sel_b_i,
  output vga_draw_pkg::pixel_t pix_o
);
  import vga_draw_pkg::*;

  pixel_t src_d;
  pixel_t pix_q;
  logic   keep_d;

  always_comb begin
    src_d  = sel_b_i ? pix_b_i : pix_a_i;
    keep_d = en_i && px_visible(src_d, X_LIM, Y_LIM);
  end

  // Coordinates and colour hold their last forwarded value whenever nothing is plotted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pix_q <= '0;
    end else if (keep_d) begin
      pix_q <= src_d;
    end else begin
      pix_q.plot <= 1'b0;
    end
  end

  assign pix_o = pix_q;

endmodule

// File: rtl/vga_draw_scheduler.sv
// Sequences clear and draw engines and shares the VGA pixel port between them.
module vga_draw_scheduler #(
  parameter int X_MAX   = vga_draw_pkg::X_MAX,
  parameter int Y_MAX   = vga_draw_pkg::Y_MAX,
  parameter int TIMEOUT = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        skip_clear,
  output logic        done,
  output logic        error,
  output logic        clr_start,
  input  logic        clr_done,
  input  logic [7:0]  clr_x,
  input  logic [6:0]  clr_y,
  input  logic [2:0]  clr_colour,
  input  logic        clr_plot,
  output logic        drw_start,
  input  logic        drw_done,
  input  logic [7:0]  drw_x,
  input  logic [6:0]  drw_y,
  input  logic [2:0]  drw_colour,
  input  logic        drw_plot,
  output logic [7:0]  vga_x,
  output logic [6:0]  vga_y,
  output logic [2:0]  vga_colour,
  output logic        vga_plot,
  output logic [14:0] plot_count
);
  import vga_draw_pkg::*;

  localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);
  localparam logic [14:0] CNT_MAX = '1;

  state_e      state_q, state_d;
  logic [15:0] wdog_q, wdog_d;
  logic [14:0] cnt_q;
  logic        clr_start_q, drw_start_q, done_q, error_q;
  pixel_t      clr_px, drw_px, vga_px;
  logic        fwd_en, fwd_drw;

  assign clr_px  = {clr_x, clr_y, clr_colour, clr_plot};
  assign drw_px  = {drw_x, drw_y, drw_colour, drw_plot};
  assign fwd_en  = (state_q == S_CLEAR) || (state_q == S_DRAW);
  assign fwd_drw = (state_q == S_DRAW);

  // An engine's done wins over a simultaneous watchdog expiry.
  always_comb begin
    state_d = state_q;
    wdog_d  = wdog_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          wdog_d  = '0;
          state_d = skip_clear ? S_DRAW : S_CLEAR;
        end
      end
      S_CLEAR: begin
        if (clr_done) begin
          state_d = S_DRAW;
          wdog_d  = '0;
        end else if (wdog_q == WD_LAST) begin
          state_d = S_FAULT;
        end else begin
          wdog_d = wdog_q + 16'd1;
        end
      end
      S_DRAW: begin
        if (drw_done) begin
          state_d = S_DONE;
        end else if (wdog_q == WD_LAST) begin
          state_d = S_FAULT;
        end else begin
          wdog_d = wdog_q + 16'd1;
        end
      end
      S_DONE, S_FAULT: begin
        if (!start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wdog_q      <= '0;
      cnt_q       <= '0;
      clr_start_q <= 1'b0;
      drw_start_q <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      wdog_q      <= wdog_d;
      clr_start_q <= (state_d == S_CLEAR);
      drw_start_q <= (state_d == S_DRAW);
      done_q      <= (state_d == S_DONE) || (state_d == S_FAULT);
      error_q     <= (state_d == S_FAULT);
      if ((state_q == S_IDLE) && start) begin
        cnt_q <= '0;
      end else if (vga_px.plot && (cnt_q != CNT_MAX)) begin
        cnt_q <= cnt_q + 15'd1;
      end
    end
  end

  pixel_clip_reg #(
    .X_LIM(X_MAX),
    .Y_LIM(Y_MAX)
  ) u_clip (
    .clk    (clk),
    .rst_n  (rst_n),
    .pix_a_i(clr_px),
    .pix_b_i(drw_px),
    .en_i   (fwd_en),
    .sel_b_i(fwd_drw),
    .pix_o  (vga_px)
  );

  assign clr_start  = clr_start_q;
  assign drw_start  = drw_start_q;
  assign done       = done_q;
  assign error      = error_q;
  assign plot_count = cnt_q;
  assign vga_x      = vga_px.x;
  assign vga_y      = vga_px.y;
  assign vga_colour = vga_px.colour;
  assign vga_plot   = vga_px.plot;

endmodule
